register_8_serializer: RTL and testbench
========================================

Name: register_8_serializer

Overview:
- Read-side companion to the 8-bit parallel-load register: captures an 8-bit register value in one cycle and streams it out one bit per accepted transfer.
- Sits between a parallel register output and a bit-serial consumer (debug/scan port, serial memory link).
- Valid/ready handshake on both sides; back-to-back words supported with no bubble cycle.

Parameters:
WIDTH, 8, bits per word; must be >= 2
LSB_FIRST, 1, 1 = bit 0 sent first; 0 = bit WIDTH-1 sent first

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-high
In  input  WIDTH  parallel word, normally driven by a register's Out
LoadValid  input  1  In holds a word to capture
LoadReady  output  1  serializer can capture In this cycle
SerOut  output  1  current serial bit
SerValid  output  1  SerOut is valid
SerReady  input  1  consumer accepts SerOut this cycle
Busy  output  1  a word is in flight
Remaining  output  $clog2(WIDTH+2)  bits still to send, including the current one

Behaviour:
- Reset (async, any time, including mid-word): state IDLE, shift register 0, Remaining 0, SerValid 0, SerOut 0, Busy 0, LoadReady 1. A partial word is discarded with no completion.
- Load fire = LoadValid & LoadReady. Bit fire = SerValid & SerReady.
- States:
  - IDLE: SerValid 0. On load fire, capture In into the shift register, set Remaining = WIDTH, go to SHIFT.
  - SHIFT: SerValid 1. SerOut = shreg[0] if LSB_FIRST, else shreg[WIDTH-1].
    - On bit fire with Remaining > 1: shift toward the output end, fill with 0, decrement Remaining.
    - On bit fire with Remaining == 1 (last bit): if load fire in the same cycle, capture In and set Remaining = WIDTH, staying in SHIFT; otherwise go to IDLE.
- LoadReady = (state == IDLE) | (SerValid & SerReady & Remaining == 1). This is combinational from SerReady, so there is no bubble between words.
- Latency: load fire in cycle N gives first SerValid in cycle N+1. One word takes WIDTH bit fires minimum.
- SerReady low holds SerOut, SerValid and Remaining stable. Once SerValid is asserted it does not drop until the bit fires.
- LoadValid is ignored while LoadReady is 0. In is sampled only on load fire, so later changes on In do not affect the word in flight.
- Busy = (state == SHIFT). Remaining is 0 in IDLE.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - One extra even-parity bit (XOR of the captured word) is sent after the data bits.
  - Load fire sets Remaining = WIDTH+1, and the last-bit and LoadReady rules apply to the parity bit.
  - The parity bit is computed at capture and held in its own flop.
- Undefined: exactly WIDTH bits are sent and no parity flop exists. This is the default.

Decomposition:
- Shared package:
  - state encoding: IDLE = 1'b0, SHIFT = 1'b1
  - default width constant: 8
  - counter width function
- One natural sub-module, serializer_shift_reg: WIDTH-bit load/shift register with load, shift and direction inputs, built from the existing dff cells with wen. The top level holds the FSM, counter and handshake logic.

Test Plan:
- Reset/idle: assert rst mid-word (after 3 bits of 8'hA5) -> next cycle SerValid 0, Busy 0, Remaining 0, LoadReady 1; the next load streams a full fresh word.
- Single word LSB-first: In=8'hA5, LoadValid pulse, SerReady=1 -> SerOut sequence 1,0,1,0,0,1,0,1 over 8 cycles starting the cycle after load; Busy drops after the 8th fire.
- MSB-first (LSB_FIRST=0): In=8'h81 -> SerOut 1,0,0,0,0,0,0,1.
- Backpressure: In=8'h3C, SerReady toggled 1,0,0,1,... -> SerOut and Remaining hold while SerReady is 0; the consumer collects 8'h3C exactly once.
- Back-to-back: LoadValid held with 8'hF0 then 8'h0F, SerReady=1 -> LoadReady pulses on the last-bit cycle; 16 consecutive valid bits, no idle cycle.
- SERIALIZER_PARITY_EN: In=8'h07 -> 8 data bits, then parity bit 1, Remaining starts at 9; In=8'h03 -> parity bit 0.

Source files
------------

// File: rtl/register_8_serializer_pkg.sv
// Shared types and sizing helpers for the register_8_serializer block.
package register_8_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Remaining must hold WIDTH+1 when the parity bit is enabled.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/register_8_serializer_shift_reg.sv
// WIDTH-bit parallel-load shift register; shifts toward bit 0 or bit WIDTH-1, filling with 0.
module serializer_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_lsb_first,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_d;
    logic             w_wen;

    assign w_wen = i_load | i_shift;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_from_up;
        logic w_from_dn;
        if (i == WIDTH - 1) begin : g_top
            assign w_from_up = 1'b0;
        end else begin : g_top
            assign w_from_up = r_q[i+1];
        end
        if (i == 0) begin : g_bot
            assign w_from_dn = 1'b0;
        end else begin : g_bot
            assign w_from_dn = r_q[i-1];
        end
        assign w_d[i] = i_load ? i_data[i] : (i_lsb_first ? w_from_up : w_from_dn);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (w_wen) begin
            r_q <= w_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/register_8_serializer.sv
// Parallel-to-serial converter with valid/ready on both sides and no bubble between words.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module register_8_serializer
    import register_8_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int LSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             In,
    input  logic                         LoadValid,
    output logic                         LoadReady,
    output logic                         SerOut,
    output logic                         SerValid,
    input  logic                         SerReady,
    output logic                         Busy,
    output logic [cnt_width(WIDTH)-1:0]  Remaining
);

    localparam int CW = cnt_width(WIDTH);
`ifdef SERIALIZER_PARITY_EN
    localparam logic [CW-1:0] LOAD_CNT = CW'(WIDTH + 1);
`else
    localparam logic [CW-1:0] LOAD_CNT = CW'(WIDTH);
`endif

    ser_state_t       r_state;
    ser_state_t       w_state_nxt;
    logic [CW-1:0]    r_remaining;
    logic [CW-1:0]    w_remaining_nxt;
    logic             w_load;
    logic             w_shift;
    logic             w_load_fire;
    logic             w_bit_fire;
    logic             w_last;
    logic             w_data_bit;
    logic [WIDTH-1:0] w_q;

    serializer_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_lsb_first(LSB_FIRST != 0),
        .i_data     (In),
        .o_q        (w_q)
    );

    assign w_bit_fire  = SerValid & SerReady;
    assign w_last      = (r_remaining == CW'(1));
    assign LoadReady   = (r_state == IDLE) | (w_bit_fire & w_last);
    assign w_load_fire = LoadValid & LoadReady;
    assign w_data_bit  = (LSB_FIRST != 0) ? w_q[0] : w_q[WIDTH-1];

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_load          = 1'b0;
        w_shift         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_load_fire) begin
                    w_load          = 1'b1;
                    w_remaining_nxt = LOAD_CNT;
                    w_state_nxt     = SHIFT;
                end
            end
            SHIFT: begin
                if (w_bit_fire) begin
                    if (!w_last) begin
                        w_shift         = 1'b1;
                        w_remaining_nxt = r_remaining - CW'(1);
                    end else if (w_load_fire) begin
                        w_load          = 1'b1;
                        w_remaining_nxt = LOAD_CNT;
                    end else begin
                        w_remaining_nxt = '0;
                        w_state_nxt     = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_remaining_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

`ifdef SERIALIZER_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^In;
        end
    end

    // The parity bit rides in the final slot after all data bits have shifted out.
    assign SerOut = (r_state == SHIFT) & (w_last ? r_parity : w_data_bit);
`else
    assign SerOut = (r_state == SHIFT) & w_data_bit;
`endif

    assign SerValid  = (r_state == SHIFT);
    assign Busy      = (r_state == SHIFT);
    assign Remaining = r_remaining;

endmodule

// File: tb/tb_register_8_serializer.sv
// Self-checking bench: an LSB-first and an MSB-first instance share all inputs,
// each output stream compared against a bit list built from the word.
module tb_register_8_serializer;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 2);
`ifdef SERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  In = '0;
    logic          LoadValid = 1'b0;
    logic          SerReady = 1'b0;
    logic          lr_l, so_l, sv_l, busy_l;
    logic          lr_m, so_m, sv_m, busy_m;
    logic [CW-1:0] rem_l, rem_m;

    int n_cmp = 0;
    int n_err = 0;

    register_8_serializer #(.WIDTH(W), .LSB_FIRST(1)) dut_lsb (
        .clk(clk), .rst(rst), .In(In), .LoadValid(LoadValid), .LoadReady(lr_l),
        .SerOut(so_l), .SerValid(sv_l), .SerReady(SerReady), .Busy(busy_l),
        .Remaining(rem_l)
    );

    register_8_serializer #(.WIDTH(W), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .rst(rst), .In(In), .LoadValid(LoadValid), .LoadReady(lr_m),
        .SerOut(so_m), .SerValid(sv_m), .SerReady(SerReady), .Busy(busy_m),
        .Remaining(rem_m)
    );

    always #5 clk = ~clk;

    // Reference: the bit a consumer should see at position k of a word.
    function automatic logic exp_bit(input logic [W-1:0] word, input bit lsb, input int k);
        if (k >= W) return ^word;
        return lsb ? word[k] : word[W-1-k];
    endfunction

    task automatic check_idle(input string tag);
        n_cmp++;
        if (sv_l !== 1'b0 || busy_l !== 1'b0 || rem_l !== '0 || lr_l !== 1'b1 || so_l !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle_lsb: sv=%b busy=%b rem=%0d lr=%b so=%b required sv=0 busy=0 rem=0 lr=1 so=0",
                     tag, sv_l, busy_l, rem_l, lr_l, so_l);
        end
        n_cmp++;
        if (sv_m !== 1'b0 || busy_m !== 1'b0 || rem_m !== '0 || lr_m !== 1'b1 || so_m !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle_msb: sv=%b busy=%b rem=%0d lr=%b so=%b required sv=0 busy=0 rem=0 lr=1 so=0",
                     tag, sv_m, busy_m, rem_m, lr_m, so_m);
        end
    endtask

    task automatic load_word(input logic [W-1:0] word);
        @(negedge clk);
        In = word; LoadValid = 1'b1; SerReady = 1'b0;
        #1;
        n_cmp++;
        if (lr_l !== 1'b1) begin
            n_err++;
            $display("FAIL load_ready_idle: got %b required 1", lr_l);
        end
        @(posedge clk);
        @(negedge clk);
        LoadValid = 1'b0;
        In = W'($urandom);
    endtask

    // Streams the remaining bits of a loaded word starting at index first,
    // checking every cycle; bp enables random consumer backpressure.
    task automatic stream_word(input logic [W-1:0] word, input int first, input bit bp, input string tag);
        int k = first;
        int cyc = 0;
        while (k < NB && cyc < 400) begin
            SerReady = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            n_cmp++;
            if (sv_l !== 1'b1 || busy_l !== 1'b1 || rem_l !== CW'(NB - k)) begin
                n_err++;
                $display("FAIL %s state k=%0d: sv=%b busy=%b rem=%0d required sv=1 busy=1 rem=%0d",
                         tag, k, sv_l, busy_l, rem_l, NB - k);
            end
            n_cmp++;
            if (so_l !== exp_bit(word, 1'b1, k) || so_m !== exp_bit(word, 1'b0, k)) begin
                n_err++;
                $display("FAIL %s bit k=%0d: lsb=%b msb=%b required lsb=%b msb=%b",
                         tag, k, so_l, so_m, exp_bit(word, 1'b1, k), exp_bit(word, 1'b0, k));
            end
            n_cmp++;
            if (lr_l !== (SerReady && k == NB - 1) || rem_m !== rem_l) begin
                n_err++;
                $display("FAIL %s load_ready k=%0d: lr=%b rem_msb=%0d required lr=%b rem=%0d",
                         tag, k, lr_l, rem_m, SerReady && k == NB - 1, rem_l);
            end
            if (SerReady) k++;
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        SerReady = 1'b0;
        n_cmp++;
        if (k != NB) begin
            n_err++;
            $display("FAIL %s timeout: sent %0d required %0d", tag, k, NB);
        end
        #1;
        check_idle(tag);
    endtask

    task automatic test_reset();
        #2;
        check_idle("reset_held");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("reset_released");
    endtask

    task automatic test_single();
        load_word(8'hA5);
        stream_word(8'hA5, 0, 1'b0, "single_a5");
        load_word(8'h81);
        stream_word(8'h81, 0, 1'b0, "single_81");
    endtask

    task automatic test_backpressure();
        load_word(8'h3C);
        stream_word(8'h3C, 0, 1'b1, "bp_3c");
    endtask

    task automatic test_reset_mid_word();
        load_word(8'hA5);
        SerReady = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        SerReady = 1'b0;
        #1;
        n_cmp++;
        if (rem_l !== CW'(NB - 3)) begin
            n_err++;
            $display("FAIL mid_rem: got %0d required %0d", rem_l, NB - 3);
        end
        rst = 1'b1;
        #1;
        check_idle("mid_reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle("mid_after");
        load_word(8'hA5);
        stream_word(8'hA5, 0, 1'b0, "fresh_a5");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1 = 8'hF0;
        logic [W-1:0] w2 = 8'h0F;
        load_word(w1);
        SerReady = 1'b1;
        for (int k = 0; k < NB; k++) begin
            LoadValid = (k == NB - 1);
            In = (k == NB - 1) ? w2 : W'($urandom);
            #1;
            n_cmp++;
            if (sv_l !== 1'b1 || so_l !== exp_bit(w1, 1'b1, k) || so_m !== exp_bit(w1, 1'b0, k)) begin
                n_err++;
                $display("FAIL b2b_w1 k=%0d: sv=%b lsb=%b msb=%b required sv=1 lsb=%b msb=%b",
                         k, sv_l, so_l, so_m, exp_bit(w1, 1'b1, k), exp_bit(w1, 1'b0, k));
            end
            n_cmp++;
            if (lr_l !== (k == NB - 1)) begin
                n_err++;
                $display("FAIL b2b_ready k=%0d: got %b required %b", k, lr_l, k == NB - 1);
            end
            @(posedge clk);
            @(negedge clk);
        end
        LoadValid = 1'b0;
        In = W'($urandom);
        stream_word(w2, 0, 1'b0, "b2b_w2");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            logic [W-1:0] w = W'($urandom);
            load_word(w);
            stream_word(w, 0, 1'b1, "random");
        end
    endtask

    task automatic test_parity();
        load_word(8'h07);
        stream_word(8'h07, 0, 1'b0, "parity_07");
        load_word(8'h03);
        stream_word(8'h03, 0, 1'b1, "parity_03");
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_reset_mid_word();
        test_back_to_back();
        test_random();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
